// File: rtl/odelay_lane_bank_pkg.sv
// Shared definitions for the programmable output delay lane bank:
// delay-type encodings and the tap stepping rule (wrap or saturate).
package odelay_lane_bank_pkg;

    localparam int DT_FIXED    = 0;
    localparam int DT_VARIABLE = 1;
    localparam int DT_VAR_LOAD = 2;
    localparam int DT_INVALID  = -1;

    // One increment/decrement step of a tap counter bounded to [0, max_tap].
    // At a limit the tap either wraps to the opposite end or holds its value.
    function automatic int step_tap(input int tap, input logic inc,
                                    input int max_tap, input logic wrap);
        if (inc) begin
            if (tap >= max_tap) begin
                return wrap ? 0 : max_tap;
            end
            return tap + 1;
        end
        if (tap <= 0) begin
            return wrap ? max_tap : 0;
        end
        return tap - 1;
    endfunction

endpackage

// File: rtl/odelay_lane_bank_lane.sv
// One delay lane: tap counter, optional load pipeline register and a
// history shift register whose tapped bit is the delayed output.
module odelay_lane
    import odelay_lane_bank_pkg::*;
#(
    parameter int TAP_BITS    = 5,
    parameter int DT_CODE     = DT_VAR_LOAD,
    parameter int DELAY_VALUE = 0,
    parameter int PIPE_SEL    = 0,
    parameter int WRAP        = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                data,
    output logic                delayed,
    input  logic                ld,
    input  logic [TAP_BITS-1:0] load_value,
    input  logic                ce,
    input  logic                inc,
    input  logic                ldpipeen,
    output logic [TAP_BITS-1:0] tap,
    output logic                tap_changed
);

    localparam int DEPTH   = 2 ** TAP_BITS;
    localparam int MAX_TAP = DEPTH - 1;
    localparam logic [TAP_BITS-1:0] INIT_TAP = TAP_BITS'(DELAY_VALUE);

    logic [DEPTH-1:0]    history_reg;
    logic [TAP_BITS-1:0] tap_reg;
    logic [TAP_BITS-1:0] tap_next;
    logic [TAP_BITS-1:0] pipe_reg;
    logic [TAP_BITS-1:0] pipe_next;
    logic                changed_reg;
    logic                changed_next;

    // Next tap and pipeline value: load has priority over stepping; FIXED lanes never move.
    always_comb begin
        tap_next  = tap_reg;
        pipe_next = pipe_reg;
        if (DT_CODE != DT_FIXED) begin
            if (ld) begin
                if (DT_CODE == DT_VARIABLE) begin
                    tap_next = INIT_TAP;
                end else begin
                    tap_next = (PIPE_SEL != 0) ? pipe_reg : load_value;
                end
            end else if (ce) begin
                tap_next = TAP_BITS'(step_tap(int'(tap_reg), inc, MAX_TAP, WRAP != 0));
            end
            if ((PIPE_SEL != 0) && ldpipeen) begin
                pipe_next = load_value;
            end
        end
        changed_next = (tap_next != tap_reg);
    end

    // Register tap, pipeline value, change flag and input history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tap_reg     <= INIT_TAP;
            pipe_reg    <= '0;
            changed_reg <= 1'b0;
            history_reg <= '0;
        end else begin
            tap_reg     <= tap_next;
            pipe_reg    <= pipe_next;
            changed_reg <= changed_next;
            history_reg <= {history_reg[DEPTH-2:0], data};
        end
    end

    // history_reg[0] is the last sample, so bit tap_reg is tap+1 edges old.
    assign delayed     = history_reg[tap_reg];
    assign tap         = tap_reg;
    assign tap_changed = changed_reg;

endmodule

// File: rtl/odelay_lane_bank.sv
// Bank of LANES independent programmable delay lanes sharing one clock.
module odelay_lane_bank
    import odelay_lane_bank_pkg::*;
#(
    parameter int    LANES       = 8,
    parameter int    TAP_BITS    = 5,
    parameter string DELAY_TYPE  = "VAR_LOAD",
    parameter int    DELAY_VALUE = 0,
    parameter int    PIPE_SEL    = 0,
    parameter int    WRAP        = 1
) (
    input  logic                      i_controller_clk,
    input  logic                      i_rst_n,
    input  logic [LANES-1:0]          i_data,
    output logic [LANES-1:0]          o_data,
    input  logic [LANES-1:0]          i_ld,
    input  logic [LANES*TAP_BITS-1:0] i_cntvaluein,
    input  logic [LANES-1:0]          i_ce,
    input  logic [LANES-1:0]          i_inc,
    input  logic [LANES-1:0]          i_ldpipeen,
    output logic [LANES*TAP_BITS-1:0] o_cntvalueout,
    output logic [LANES-1:0]          o_tap_changed
);

    localparam int DT_CODE = (DELAY_TYPE == "FIXED")    ? DT_FIXED    :
                             (DELAY_TYPE == "VARIABLE") ? DT_VARIABLE :
                             (DELAY_TYPE == "VAR_LOAD") ? DT_VAR_LOAD : DT_INVALID;

    // Reject unusable configurations before any hardware is built.
    generate
        if (DT_CODE == DT_INVALID) begin : g_bad_type
            $error("odelay_lane_bank: unknown DELAY_TYPE %s", DELAY_TYPE);
        end
        if ((DELAY_VALUE < 0) || (DELAY_VALUE > (2 ** TAP_BITS) - 1)) begin : g_bad_value
            $error("odelay_lane_bank: DELAY_VALUE %0d outside tap range", DELAY_VALUE);
        end
        if ((LANES < 1) || (LANES > 32)) begin : g_bad_lanes
            $error("odelay_lane_bank: LANES %0d outside 1..32", LANES);
        end
        if (TAP_BITS < 1) begin : g_bad_taps
            $error("odelay_lane_bank: TAP_BITS must be at least 1");
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            odelay_lane #(
                .TAP_BITS    (TAP_BITS),
                .DT_CODE     (DT_CODE),
                .DELAY_VALUE (DELAY_VALUE),
                .PIPE_SEL    (PIPE_SEL),
                .WRAP        (WRAP)
            ) u_lane (
                .clk         (i_controller_clk),
                .rst_n       (i_rst_n),
                .data        (i_data[gi]),
                .delayed     (o_data[gi]),
                .ld          (i_ld[gi]),
                .load_value  (i_cntvaluein[gi*TAP_BITS +: TAP_BITS]),
                .ce          (i_ce[gi]),
                .inc         (i_inc[gi]),
                .ldpipeen    (i_ldpipeen[gi]),
                .tap         (o_cntvalueout[gi*TAP_BITS +: TAP_BITS]),
                .tap_changed (o_tap_changed[gi])
            );
        end
    endgenerate

endmodule
